// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the synchronous-read instruction memory, re-aligns its
// 1-cycle read data with the fetch PC, and holds the instruction stable across decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          imem_pc,
  output logic                 imem_is_jump,
  input  logic [31:0]          imem_inst,
  output logic                 id_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_inst,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INST_STEP = 4;

  logic [XLEN-1:0]      pc_f, pc_f_nxt;
  logic [XLEN-1:0]      pc_d, pc_d_nxt;
  logic                 valid_d, valid_d_nxt;
  logic [XLEN-1:0]      hold_inst, hold_inst_nxt;
  logic                 hold_valid, hold_valid_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [XLEN-1:0]      redirect_target;
  logic [1:0]           unused_redirect_lsb;

  // Targets are word aligned; the low address bits from execute carry no meaning here.
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = redirect_pc[1:0];

  // Next-state: redirect beats stall beats advance; reset is applied in the register block.
  always_comb begin
    pc_f_nxt       = pc_f;
    pc_d_nxt       = pc_d;
    valid_d_nxt    = valid_d;
    hold_inst_nxt  = hold_inst;
    hold_valid_nxt = hold_valid;
    cnt_nxt        = cnt;
    if (redirect) begin
      pc_f_nxt       = redirect_target;
      valid_d_nxt    = 1'b0;
      hold_valid_nxt = 1'b0;
    end else if (stall) begin
      // Memory re-reads pc_f every clock, so the presented word must be captured once.
      if (valid_d && !hold_valid) begin
        hold_inst_nxt  = imem_inst;
        hold_valid_nxt = 1'b1;
      end
    end else begin
      pc_d_nxt       = pc_f;
      pc_f_nxt       = pc_f + XLEN'(INST_STEP);
      valid_d_nxt    = 1'b1;
      hold_valid_nxt = 1'b0;
      if (valid_d) begin
        cnt_nxt = cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f       <= RESET_PC;
      pc_d       <= '0;
      valid_d    <= 1'b0;
      hold_inst  <= '0;
      hold_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      pc_f       <= pc_f_nxt;
      pc_d       <= pc_d_nxt;
      valid_d    <= valid_d_nxt;
      hold_inst  <= hold_inst_nxt;
      hold_valid <= hold_valid_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Memory flush must react in the same cycle as the redirect, hence combinational.
  assign imem_is_jump = redirect | ~rst_n;
  assign imem_pc      = pc_f;

  always_comb begin
    id_inst = NOP_INST;
    if (valid_d) begin
      id_inst = hold_valid ? hold_inst : imem_inst;
    end
  end

  assign id_valid    = valid_d;
  assign id_pc       = pc_d;
  assign fetch_count = cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: synchronous-read memory model, directed plus random control stimulus,
// and a per-cycle scoreboard fed by a program-order reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int unsigned CW       = 32;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   imem_pc;
  logic          imem_is_jump;
  logic [31:0]   imem_inst;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic [CW-1:0] fetch_count;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_pc(imem_pc), .imem_is_jump(imem_is_jump),
    .imem_inst(imem_inst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address, so any PC has a known word.
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0001;
  endfunction

  // Synchronous-read instruction memory with flush.
  always @(posedge clk) imem_inst <= imem_is_jump ? NOP_INST : word(imem_pc);

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] fpc;
    logic [31:0] cnt;
    logic        jmp;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model in program-order terms: what decode shows and what comes next.
  logic        m_shown;
  logic [31:0] m_pc;
  logic [31:0] m_next;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Apply one cycle of control inputs and push the state expected after the next edge.
  task automatic step(input logic r, input logic red, input logic [31:0] rpc, input logic st);
    exp_t e;
    rst_n = r; redirect = red; redirect_pc = rpc; stall = st;
    if (!r) begin
      m_shown = 1'b0; m_pc = 32'h0; m_next = RESET_PC; m_cnt = 32'h0;
    end else if (red) begin
      m_shown = 1'b0; m_next = rpc & ~32'h3;
    end else if (!st) begin
      if (m_shown) m_cnt = m_cnt + 32'd1;
      m_pc = m_next; m_next = m_next + 32'd4; m_shown = 1'b1;
    end
    e.v    = m_shown;
    e.pc   = m_pc;
    e.inst = m_shown ? word(m_pc) : NOP_INST;
    e.fpc  = m_next;
    e.cnt  = m_cnt;
    e.jmp  = red | ~r;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); step(1'b1, 1'b0, 32'h0, 1'b0); end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); step(1'b1, 1'b0, 32'h0, 1'b1); end
  endtask

  task automatic jump(input logic [31:0] t, input logic st);
    @(negedge clk); step(1'b1, 1'b1, t, st);
  endtask

  // Monitor: every cycle the DUT presents a state, compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        chk("id_valid",     32'(id_valid),     32'(e.v));
        chk("id_pc",        id_pc,             e.pc);
        chk("id_inst",      id_inst,           e.inst);
        chk("imem_pc",      imem_pc,           e.fpc);
        chk("fetch_count",  32'(fetch_count),  e.cnt);
        chk("imem_is_jump", 32'(imem_is_jump), 32'(e.jmp));
      end
    end
  end

  initial begin
    int pick;
    logic [31:0] tgt;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; rst_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); step(1'b0, 1'b0, 32'h0, 1'b0);
    // Straight-line fetch, then a 3-cycle stall while id_pc=8.
    run(3);
    hold(3);
    run(3);
    // Redirect, redirect coinciding with stall, back-to-back redirects.
    jump(32'h0000_0040, 1'b0); run(3);
    hold(1);
    jump(32'h0000_0103, 1'b1); run(3);
    jump(32'h0000_0020, 1'b0);
    jump(32'h0000_0080, 1'b0); run(3);
    // Reset asserted mid-stream during a stall.
    hold(2);
    @(negedge clk); step(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk); step(1'b0, 1'b0, 32'h0, 1'b1);
    run(4);
    // PC wrap at the top of the address space, with a stall straddling it.
    jump(32'hFFFF_FFF6, 1'b0); run(2); hold(2); run(3);
    // Randomized control mix.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      pick = int'($urandom_range(99));
      tgt  = ($urandom_range(3) == 0) ? $urandom : (32'($urandom_range(255)) << 2) | 32'($urandom_range(3));
      if (pick < 1)       step(1'b0, 1'b0, 32'h0, 1'($urandom_range(1)));
      else if (pick < 11) step(1'b1, 1'b1, tgt, 1'($urandom_range(1)));
      else if (pick < 40) step(1'b1, 1'b0, 32'h0, 1'b1);
      else                step(1'b1, 1'b0, 32'h0, 1'b0);
    end
    @(posedge clk); #3;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
